// File: rtl/branch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | branch_ctrl: jump/branch/call/return decoder with return-address stack,    |
// | registered one-cycle PC load pulse and wrong-path flush.   Rev 1.0         |
// +----------------------------------------------------------------------------+
module branch_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     instr_valid,
  input  logic [2:0]               op,
  input  logic [ADDR_W-1:0]        target,
  input  logic [ADDR_W-1:0]        instr_pc,
  input  logic                     zero_flag,
  output logic                     load,
  output logic [ADDR_W-1:0]        new_addr,
  output logic                     flush,
  output logic [$clog2(DEPTH):0]   sp,
  output logic                     stack_full,
  output logic                     stack_empty,
  output logic                     err_ovf,
  output logic                     err_unf
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int SP_W  = PTR_W + 1;

  localparam logic [2:0] OP_JMP  = 3'd1;
  localparam logic [2:0] OP_JZ   = 3'd2;
  localparam logic [2:0] OP_JNZ  = 3'd3;
  localparam logic [2:0] OP_CALL = 3'd4;
  localparam logic [2:0] OP_RET  = 3'd5;

  logic [ADDR_W-1:0] stack_mem [DEPTH];

  logic              accept;
  logic              taken;
  logic              push;
  logic              pop;
  logic              ovf_evt;
  logic              unf_evt;
  logic [ADDR_W-1:0] next_addr;
  logic [PTR_W-1:0]  push_idx;
  logic [PTR_W-1:0]  pop_idx;

  assign stack_full  = (sp == SP_W'(DEPTH));
  assign stack_empty = (sp == '0);
  assign flush       = load;

  // Low pointer bits suffice: push only happens below DEPTH, and sp==DEPTH wraps to the last slot.
  assign push_idx = sp[PTR_W-1:0];
  assign pop_idx  = sp[PTR_W-1:0] - PTR_W'(1);

  // The shadow cycle (load high) blocks acceptance, so loads can never be back-to-back.
  assign accept = instr_valid && !load;

  always_comb begin
    taken     = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    ovf_evt   = 1'b0;
    unf_evt   = 1'b0;
    next_addr = target;
    if (accept) begin
      case (op)
        OP_JMP: taken = 1'b1;
        OP_JZ:  taken = zero_flag;
        OP_JNZ: taken = !zero_flag;
        OP_CALL: begin
          if (stack_full) begin
            ovf_evt = 1'b1;
          end else begin
            push  = 1'b1;
            taken = 1'b1;
          end
        end
        OP_RET: begin
          if (stack_empty) begin
            unf_evt = 1'b1;
          end else begin
            pop       = 1'b1;
            taken     = 1'b1;
            next_addr = stack_mem[pop_idx];
          end
        end
        default: taken = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      load     <= 1'b0;
      new_addr <= '0;
      sp       <= '0;
      err_ovf  <= 1'b0;
      err_unf  <= 1'b0;
    end else begin
      load <= taken;
      if (taken) begin
        new_addr <= next_addr;
      end
      if (push) begin
        sp <= sp + SP_W'(1);
      end else if (pop) begin
        sp <= sp - SP_W'(1);
      end
      if (ovf_evt) begin
        err_ovf <= 1'b1;
      end
      if (unf_evt) begin
        err_unf <= 1'b1;
      end
    end
  end

  // Stack contents are don't-care after reset, so the storage carries no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      stack_mem[push_idx] <= instr_pc + ADDR_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_branch_ctrl: directed and random stimulus against a queue-based model.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_branch_ctrl;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 4;

  logic              clk;
  logic              reset_n;
  logic              instr_valid;
  logic [2:0]        op;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] instr_pc;
  logic              zero_flag;
  logic              load;
  logic [ADDR_W-1:0] new_addr;
  logic              flush;
  logic [2:0]        sp;
  logic              stack_full;
  logic              stack_empty;
  logic              err_ovf;
  logic              err_unf;

  int errors = 0;
  int checks = 0;

  branch_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .instr_valid(instr_valid), .op(op),
    .target(target), .instr_pc(instr_pc), .zero_flag(zero_flag),
    .load(load), .new_addr(new_addr), .flush(flush), .sp(sp),
    .stack_full(stack_full), .stack_empty(stack_empty),
    .err_ovf(err_ovf), .err_unf(err_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the return stack is a plain queue.
  logic              m_load;
  logic [ADDR_W-1:0] m_addr;
  logic              m_ovf;
  logic              m_unf;
  logic [ADDR_W-1:0] m_stack[$];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_load = 1'b0;
      m_addr = '0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
      m_stack.delete();
    end else if (m_load) begin
      m_load = 1'b0;
    end else if (instr_valid) begin
      case (op)
        3'd1: begin m_load = 1'b1; m_addr = target; end
        3'd2: if (zero_flag) begin m_load = 1'b1; m_addr = target; end
        3'd3: if (!zero_flag) begin m_load = 1'b1; m_addr = target; end
        3'd4: begin
          if (m_stack.size() < DEPTH) begin
            m_stack.push_back(instr_pc + 8'd1);
            m_load = 1'b1;
            m_addr = target;
          end else begin
            m_ovf = 1'b1;
          end
        end
        3'd5: begin
          if (m_stack.size() > 0) begin
            m_addr = m_stack.pop_back();
            m_load = 1'b1;
          end else begin
            m_unf = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      check("m_load",  {31'd0, load},        {31'd0, m_load});
      check("m_flush", {31'd0, flush},       {31'd0, m_load});
      check("m_addr",  {24'd0, new_addr},    {24'd0, m_addr});
      check("m_sp",    {29'd0, sp},          m_stack.size());
      check("m_full",  {31'd0, stack_full},  {31'd0, m_stack.size() == DEPTH});
      check("m_empty", {31'd0, stack_empty}, {31'd0, m_stack.size() == 0});
      check("m_ovf",   {31'd0, err_ovf},     {31'd0, m_ovf});
      check("m_unf",   {31'd0, err_unf},     {31'd0, m_unf});
    end
  end

  // Present one op for one cycle; returns at the negedge just after the accepting edge.
  task automatic issue(input logic [2:0] o, input logic [7:0] t, input logic [7:0] pc, input logic zf);
    @(negedge clk);
    instr_valid = 1'b1;
    op          = o;
    target      = t;
    instr_pc    = pc;
    zero_flag   = zf;
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  initial begin
    reset_n     = 1'b0;
    instr_valid = 1'b0;
    op          = '0;
    target      = '0;
    instr_pc    = '0;
    zero_flag   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_load", {31'd0, load}, 32'd0);
    check("rst_addr", {24'd0, new_addr}, 32'd0);
    check("rst_sp", {29'd0, sp}, 32'd0);
    check("rst_empty", {31'd0, stack_empty}, 32'd1);
    reset_n = 1'b1;

    issue(3'd1, 8'h40, 8'h00, 1'b0);
    check("jmp_load", {31'd0, load}, 32'd1);
    check("jmp_addr", {24'd0, new_addr}, 32'h40);
    check("jmp_flush", {31'd0, flush}, 32'd1);
    @(negedge clk);
    check("jmp_pulse_end", {31'd0, load}, 32'd0);

    issue(3'd2, 8'h10, 8'h00, 1'b0);
    check("jz_nt_load", {31'd0, load}, 32'd0);
    issue(3'd2, 8'h10, 8'h00, 1'b1);
    check("jz_t_load", {31'd0, load}, 32'd1);
    check("jz_t_addr", {24'd0, new_addr}, 32'h10);

    issue(3'd4, 8'h80, 8'h05, 1'b0);
    check("call_addr", {24'd0, new_addr}, 32'h80);
    check("call_sp", {29'd0, sp}, 32'd1);
    issue(3'd5, 8'h00, 8'h00, 1'b0);
    check("ret_load", {31'd0, load}, 32'd1);
    check("ret_addr", {24'd0, new_addr}, 32'h06);
    check("ret_sp", {29'd0, sp}, 32'd0);

    for (int i = 1; i <= 4; i++) issue(3'd4, 8'h90, 8'(i), 1'b0);
    check("full_flag", {31'd0, stack_full}, 32'd1);
    issue(3'd4, 8'h90, 8'h09, 1'b0);
    check("ovf_load", {31'd0, load}, 32'd0);
    check("ovf_err", {31'd0, err_ovf}, 32'd1);
    check("ovf_sp", {29'd0, sp}, 32'd4);
    for (int i = 0; i < 4; i++) begin
      issue(3'd5, 8'h00, 8'h00, 1'b0);
      check("lifo_addr", {24'd0, new_addr}, 32'(5 - i));
    end
    issue(3'd5, 8'h00, 8'h00, 1'b0);
    check("unf_load", {31'd0, load}, 32'd0);
    check("unf_err", {31'd0, err_unf}, 32'd1);

    // CALL held into the shadow cycle of a JMP must be ignored.
    @(negedge clk);
    instr_valid = 1'b1; op = 3'd1; target = 8'h20; instr_pc = 8'h30;
    @(negedge clk);
    check("shadow_jmp_addr", {24'd0, new_addr}, 32'h20);
    op = 3'd4; target = 8'h70;
    @(negedge clk);
    instr_valid = 1'b0;
    check("shadow_load", {31'd0, load}, 32'd0);
    check("shadow_sp", {29'd0, sp}, 32'd0);

    issue(3'd4, 8'h55, 8'hFF, 1'b0);
    issue(3'd5, 8'h00, 8'h00, 1'b0);
    check("wrap_addr", {24'd0, new_addr}, 32'h00);

    issue(3'd4, 8'h66, 8'h10, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    check("async_load", {31'd0, load}, 32'd0);
    check("async_flush", {31'd0, flush}, 32'd0);
    check("async_sp", {29'd0, sp}, 32'd0);
    check("async_ovf", {31'd0, err_ovf}, 32'd0);
    check("async_unf", {31'd0, err_unf}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      instr_valid = ($urandom_range(0, 3) != 0);
      op          = 3'($urandom_range(0, 7));
      target      = 8'($urandom);
      instr_pc    = 8'($urandom);
      zero_flag   = 1'($urandom);
    end
    @(negedge clk);
    instr_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
